// File: rtl/circuit_sched.sv
// circuit_sched: round-robin front end that shares one pulsed-enable
// datapath among NREQ requesters. It keeps one transaction in flight:
// it grants a requester, pulses the datapath, waits LATENCY cycles, then
// returns the result on a single valid/ready response channel.
//
// state | meaning
// IDLE  | no transaction; grant the next valid requester in round-robin order
// ISSUE | circ_en high for this single cycle with circ_x holding the operand
// WAIT  | counting down the datapath latency; capture circ_y when count is 1
// RESP  | rsp_valid high with id/data held until rsp_ready
module circuit_sched #(
  parameter int DATA_W  = 32,
  parameter int NREQ    = 4,
  parameter int LATENCY = 1,
  parameter int ID_W    = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   circ_en,
  output logic [DATA_W-1:0]      circ_x,
  input  logic [DATA_W-1:0]      circ_y,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [DATA_W-1:0]      rsp_data,
  input  logic                   rsp_ready,
  output logic                   busy
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] circ_x_q, circ_x_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              circ_en_q, circ_en_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              busy_q, busy_d;

  logic              grant_vld;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   srch_idx;
  logic [DATA_W-1:0] grant_data;

  // Round-robin search: first valid requester after last_grant, with wrap.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    srch_idx  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      srch_idx = ID_W'((int'(last_grant_q) + i) % NREQ);
      if (!grant_vld && req_valid[srch_idx]) begin
        grant_vld = 1'b1;
        grant_idx = srch_idx;
      end
    end
  end

  // Operand of the granted requester.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (ID_W'(i) == grant_idx) grant_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Accept strobe is the only combinational output; forced low while in reset.
  always_comb begin
    req_ready = '0;
    if (!rst && state_q == IDLE && grant_vld) req_ready[grant_idx] = 1'b1;
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_id_d     = rsp_id_q;
    circ_x_d     = circ_x_q;
    rsp_data_d   = rsp_data_q;
    cnt_d        = cnt_q;
    circ_en_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          circ_x_d     = grant_data;
          rsp_id_d     = grant_idx;
          last_grant_d = grant_idx;
          circ_en_d    = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(LATENCY);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          rsp_data_d = circ_y;
          cnt_d      = '0;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NREQ - 1);
      rsp_id_q     <= '0;
      circ_x_q     <= '0;
      rsp_data_q   <= '0;
      cnt_q        <= '0;
      circ_en_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      circ_x_q     <= circ_x_d;
      rsp_data_q   <= rsp_data_d;
      cnt_q        <= cnt_d;
      circ_en_q    <= circ_en_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign circ_en   = circ_en_q;
  assign circ_x    = circ_x_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_circuit_sched.sv
// Bench for circuit_sched: a LATENCY=1 instance and a LATENCY=4 instance,
// each with a small datapath model, checked against a round-robin
// reference model and fixed latency/throughput expectations.
module tb_circuit_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last1, last4;

  // LATENCY=1 instance signals
  logic [3:0]   req_valid1, req_ready1;
  logic [31:0]  data1 [4];
  logic [127:0] req_data1;
  logic         circ_en1, rsp_valid1, rsp_ready1, busy1;
  logic [31:0]  circ_x1, circ_y1, rsp_data1;
  logic [1:0]   rsp_id1;

  // LATENCY=4 instance signals
  logic [3:0]   req_valid4, req_ready4;
  logic [31:0]  data4 [4];
  logic [127:0] req_data4;
  logic         circ_en4, rsp_valid4, rsp_ready4, busy4;
  logic [31:0]  circ_x4, circ_y4, rsp_data4;
  logic [1:0]   rsp_id4;
  logic [31:0]  pipe4 [4];

  assign req_data1 = {data1[3], data1[2], data1[1], data1[0]};
  assign req_data4 = {data4[3], data4[2], data4[1], data4[0]};

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath models: y = x + 1 after one edge; y = 3x + 7 after four edges.
  always @(posedge clk) if (circ_en1) circ_y1 <= circ_x1 + 32'd1;
  always @(posedge clk) begin
    if (circ_en4) pipe4[0] <= circ_x4 * 32'd3 + 32'd7;
    pipe4[1] <= pipe4[0];
    pipe4[2] <= pipe4[1];
    pipe4[3] <= pipe4[2];
  end
  assign circ_y4 = pipe4[3];

  circuit_sched #(.DATA_W(32), .NREQ(4), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_data(req_data1),
    .req_ready(req_ready1), .circ_en(circ_en1), .circ_x(circ_x1),
    .circ_y(circ_y1), .rsp_valid(rsp_valid1), .rsp_id(rsp_id1),
    .rsp_data(rsp_data1), .rsp_ready(rsp_ready1), .busy(busy1)
  );

  circuit_sched #(.DATA_W(32), .NREQ(4), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid4), .req_data(req_data4),
    .req_ready(req_ready4), .circ_en(circ_en4), .circ_x(circ_x4),
    .circ_y(circ_y4), .rsp_valid(rsp_valid4), .rsp_id(rsp_id4),
    .rsp_data(rsp_data4), .rsp_ready(rsp_ready4), .busy(busy4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbiter: rotate the valid mask so the slot after the last
  // grant sits at bit 0, take the lowest set bit, rotate back.
  function automatic int rr_pick(input logic [3:0] v, input int last);
    logic [7:0] dbl;
    logic [3:0] rot;
    dbl = {v, v} >> ((last + 1) % 4);
    rot = dbl[3:0];
    for (int k = 0; k < 4; k++) if (rot[k]) return (last + 1 + k) % 4;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the LATENCY=1 instance, with bp cycles of response
  // backpressure. Entered and left one time unit after a rising edge.
  task automatic txn1(input int bp);
    int g, n;
    logic [31:0] x;
    rsp_ready1 = (bp == 0);
    #1;
    n = 0;
    while (req_ready1 == 4'b0 && n < 20) begin
      tick();
      #1;
      n++;
    end
    chk("grant_timeout", 64'(n < 20), 64'd1);
    g = rr_pick(req_valid1, last1);
    chk("grant", 64'(req_ready1), 64'd1 << g);
    x = data1[g];
    last1 = g;
    tick();
    data1[g] = $urandom;
    chk("issue_en", 64'(circ_en1), 64'd1);
    chk("issue_x", 64'(circ_x1), 64'(x));
    chk("issue_ready", 64'(req_ready1), 64'd0);
    tick();
    chk("wait_en", 64'(circ_en1), 64'd0);
    chk("wait_vld", 64'(rsp_valid1), 64'd0);
    tick();
    chk("rsp_vld", 64'(rsp_valid1), 64'd1);
    chk("rsp_id", 64'(rsp_id1), 64'(g));
    chk("rsp_data", 64'(rsp_data1), 64'(x + 32'd1));
    for (int k = 0; k < bp; k++) begin
      tick();
      chk("bp_vld", 64'(rsp_valid1), 64'd1);
      chk("bp_id", 64'(rsp_id1), 64'(g));
      chk("bp_data", 64'(rsp_data1), 64'(x + 32'd1));
      chk("bp_ready", 64'(req_ready1), 64'd0);
      chk("bp_en", 64'(circ_en1), 64'd0);
    end
    rsp_ready1 = 1'b1;
    tick();
    chk("idle_vld", 64'(rsp_valid1), 64'd0);
    chk("idle_busy", 64'(busy1), 64'd0);
    chk("regrant", 64'(req_ready1 != 4'b0), 64'(req_valid1 != 4'b0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n, g, en_cyc, prev_en;
    logic [31:0] x;

    // Reset with every requester valid.
    rst = 1'b1;
    req_valid1 = 4'hF; req_valid4 = 4'hF;
    rsp_ready1 = 1'b1; rsp_ready4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data1[i] = $urandom;
      data4[i] = $urandom;
    end
    #10;
    chk("rst_ready1", 64'(req_ready1), 64'd0);
    chk("rst_en1", 64'(circ_en1), 64'd0);
    chk("rst_x1", 64'(circ_x1), 64'd0);
    chk("rst_vld1", 64'(rsp_valid1), 64'd0);
    chk("rst_id1", 64'(rsp_id1), 64'd0);
    chk("rst_data1", 64'(rsp_data1), 64'd0);
    chk("rst_busy1", 64'(busy1), 64'd0);
    chk("rst_ready4", 64'(req_ready4), 64'd0);
    chk("rst_busy4", 64'(busy4), 64'd0);
    chk("rst_data4", 64'(rsp_data4), 64'd0);
    #2;
    rst = 1'b0;
    last1 = 3; last4 = 3;
    #1;
    chk("first_grant1", 64'(req_ready1), 64'h1);
    chk("first_grant4", 64'(req_ready4), 64'h1);
    req_valid1 = 4'h0; req_valid4 = 4'h0;
    tick();

    // Round-robin fairness with all four requesters valid.
    req_valid1 = 4'hF;
    for (int i = 0; i < 8; i++) begin
      txn1(0);
      chk("rr_order", 64'(last1), 64'(i % 4));
    end

    // Single request from requester 2 with operand 5.
    req_valid1 = 4'b0100;
    data1[2] = 32'h0000_0005;
    txn1(0);
    chk("single_id", 64'(last1), 64'd2);

    // Response backpressure with another requester waiting.
    req_valid1 = 4'b0011;
    txn1(20);
    txn1(0);

    // Randomized masks and backpressure.
    for (int i = 0; i < 24; i++) begin
      req_valid1 = 4'($urandom_range(1, 15));
      txn1(int'($urandom_range(0, 3)));
    end
    req_valid1 = 4'h0;

    // LATENCY=4 stream from requester 0.
    prev_en = 0;
    for (int i = 0; i < 100; i++) begin
      x = 32'(i);
      data4[0] = x;
      req_valid4 = 4'b0001;
      #1;
      n = 0;
      while (req_ready4 == 4'b0 && n < 20) begin
        tick();
        #1;
        n++;
      end
      chk("l4_grant_timeout", 64'(n < 20), 64'd1);
      chk("l4_grant", 64'(req_ready4), 64'h1);
      last4 = 0;
      tick();
      en_cyc = cyc;
      chk("l4_en", 64'(circ_en4), 64'd1);
      chk("l4_x", 64'(circ_x4), 64'(x));
      if (i > 0) chk("l4_spacing", 64'(en_cyc - prev_en), 64'd7);
      prev_en = en_cyc;
      for (int k = 0; k < 4; k++) begin
        tick();
        chk("l4_wait_en", 64'(circ_en4), 64'd0);
        chk("l4_wait_vld", 64'(rsp_valid4), 64'd0);
      end
      tick();
      chk("l4_rsp_vld", 64'(rsp_valid4), 64'd1);
      chk("l4_rsp_id", 64'(rsp_id4), 64'd0);
      chk("l4_rsp_data", 64'(rsp_data4), 64'(x * 32'd3 + 32'd7));
      chk("l4_rsp_en", 64'(circ_en4), 64'd0);
      tick();
      chk("l4_idle_vld", 64'(rsp_valid4), 64'd0);
      chk("l4_idle_en", 64'(circ_en4), 64'd0);
    end
    req_valid4 = 4'h0;

    // Reset during WAIT on the LATENCY=4 instance.
    data4[2] = $urandom;
    req_valid4 = 4'b0100;
    #1;
    g = rr_pick(req_valid4, last4);
    chk("mr_grant", 64'(req_ready4), 64'd1 << g);
    tick();
    chk("mr_issue_en", 64'(circ_en4), 64'd1);
    req_valid4 = 4'h0;
    tick();
    tick();
    chk("mr_in_wait", 64'(busy4), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_busy", 64'(busy4), 64'd0);
    chk("mr_en", 64'(circ_en4), 64'd0);
    chk("mr_vld", 64'(rsp_valid4), 64'd0);
    chk("mr_ready", 64'(req_ready4), 64'd0);
    tick();
    rst = 1'b0;
    last4 = 3; last1 = 3;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("mr_no_rsp", 64'(rsp_valid4), 64'd0);
      chk("mr_idle", 64'(busy4), 64'd0);
    end
    req_valid4 = 4'b1010;
    #1;
    g = rr_pick(req_valid4, last4);
    chk("mr_next_grant", 64'(req_ready4), 64'd1 << g);
    chk("mr_lowest", 64'(req_ready4), 64'b0010);
    x = data4[1];
    tick();
    req_valid4 = 4'h0;
    chk("mr_next_en", 64'(circ_en4), 64'd1);
    chk("mr_next_x", 64'(circ_x4), 64'(x));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
